// File: rtl/writeback_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : writeback_acceptor
// Description : Consumer end of the functional-unit writeback handshake.
//               Units raise done_next_cycle; one eligible unit per cycle is
//               granted and told through the registered one-hot 'accepted'.
//               In the following cycle that unit's result, destination and
//               instruction ID are registered onto a single register-file
//               write port and a retire-ID stream.
//
//               Arbitration policy:
//                 WB_ROUND_ROBIN_EN undefined : fixed priority, lowest wins
//                 WB_ROUND_ROBIN_EN defined   : rotating priority from rr_ptr
//
// Ports       : clk, rst            clock, synchronous active-high reset
//               done_next_cycle     per-unit request
//               unit_rd             per-unit result, slice [i*XLEN +: XLEN]
//               unit_rd_addr        per-unit destination register (5 bits)
//               unit_id             per-unit instruction ID
//               wb_stall            suppress new grants this cycle
//               accepted            one-hot, registered grant
//               rf_we/rf_addr/rf_data  register-file write port (no x0 write)
//               retire_valid/retire_id retire stream (x0 included)
//
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_acceptor #(
    parameter int NUM_UNITS = 4,
    parameter int XLEN      = 32,
    parameter int ID_W      = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_UNITS-1:0]      done_next_cycle,
    input  logic [NUM_UNITS*XLEN-1:0] unit_rd,
    input  logic [NUM_UNITS*5-1:0]    unit_rd_addr,
    input  logic [NUM_UNITS*ID_W-1:0] unit_id,
    input  logic                      wb_stall,
    output logic [NUM_UNITS-1:0]      accepted,
    output logic                      rf_we,
    output logic [4:0]                rf_addr,
    output logic [XLEN-1:0]           rf_data,
    output logic                      retire_valid,
    output logic [ID_W-1:0]           retire_id
);

    // ------------------------------------------------------------------
    // Grant stage
    // ------------------------------------------------------------------
    // The unit currently in 'accepted' still holds its request during its
    // capture cycle; masking it prevents granting the same result twice.
    logic [NUM_UNITS-1:0] w_eligible;
    logic [NUM_UNITS-1:0] w_grant;

    assign w_eligible = done_next_cycle & ~accepted & {NUM_UNITS{~wb_stall}};

`ifdef WB_ROUND_ROBIN_EN
    localparam int PTR_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_grant_idx;
    logic             w_found;

    // Search order is rr_ptr, rr_ptr+1, ... wrapping at NUM_UNITS-1.
    // Unit indices stay constant per comparator so no variable indexing
    // of the request vector is needed.
    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (!w_found && w_eligible[i] &&
                    (i == ((int'(r_rr_ptr) + k) % NUM_UNITS))) begin
                    w_found     = 1'b1;
                    w_grant[i]  = 1'b1;
                    w_grant_idx = PTR_W'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_found) begin
            r_rr_ptr <= (w_grant_idx == PTR_W'(NUM_UNITS - 1)) ? '0
                                                               : w_grant_idx + 1'b1;
        end
    end
`else
    logic w_found;

    // Lowest index wins.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (!w_found && w_eligible[i]) begin
                w_found    = 1'b1;
                w_grant[i] = 1'b1;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Capture stage: select the accepted unit's fields (one-hot mux)
    // ------------------------------------------------------------------
    logic            w_capture;
    logic [XLEN-1:0] w_sel_rd;
    logic [4:0]      w_sel_addr;
    logic [ID_W-1:0] w_sel_id;

    // Pipeline is in its CAPTURE state whenever any grant is outstanding.
    assign w_capture = |accepted;

    always_comb begin
        w_sel_rd   = '0;
        w_sel_addr = '0;
        w_sel_id   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (accepted[i]) begin
                w_sel_rd   = unit_rd[i*XLEN +: XLEN];
                w_sel_addr = unit_rd_addr[i*5 +: 5];
                w_sel_id   = unit_id[i*ID_W +: ID_W];
            end
        end
    end

    // Reset drops any grant or capture in flight; units re-present later.
    always_ff @(posedge clk) begin
        if (rst) begin
            accepted     <= '0;
            rf_we        <= 1'b0;
            rf_addr      <= '0;
            rf_data      <= '0;
            retire_valid <= 1'b0;
            retire_id    <= '0;
        end else begin
            accepted <= w_grant;
            if (w_capture) begin
                rf_data      <= w_sel_rd;
                rf_addr      <= w_sel_addr;
                retire_id    <= w_sel_id;
                retire_valid <= 1'b1;
                rf_we        <= (w_sel_addr != 5'd0);
            end else begin
                // Address/data/ID hold their last values when idle.
                rf_we        <= 1'b0;
                retire_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_acceptor
// Description : Randomized scoreboard bench for writeback_acceptor. Each unit
//               is modelled as a FIFO of pending results that it presents
//               while non-empty. A transaction-level model decides which unit
//               the arbiter must pick each cycle and pushes the expected
//               writeback; a monitor pops and compares whenever retire_valid
//               is seen. Build with +define+WB_ROUND_ROBIN_EN to match a
//               round-robin DUT build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_acceptor;

    localparam int N    = 4;
    localparam int XLEN = 32;
    localparam int ID_W = 3;
    localparam int DEPTH = 16;

    logic                 clk;
    logic                 rst;
    logic [N-1:0]         done_next_cycle;
    logic [N*XLEN-1:0]    unit_rd;
    logic [N*5-1:0]       unit_rd_addr;
    logic [N*ID_W-1:0]    unit_id;
    logic                 wb_stall;
    logic [N-1:0]         accepted;
    logic                 rf_we;
    logic [4:0]           rf_addr;
    logic [XLEN-1:0]      rf_data;
    logic                 retire_valid;
    logic [ID_W-1:0]      retire_id;

    writeback_acceptor #(
        .NUM_UNITS (N),
        .XLEN      (XLEN),
        .ID_W      (ID_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .done_next_cycle (done_next_cycle),
        .unit_rd         (unit_rd),
        .unit_rd_addr    (unit_rd_addr),
        .unit_id         (unit_id),
        .wb_stall        (wb_stall),
        .accepted        (accepted),
        .rf_we           (rf_we),
        .rf_addr         (rf_addr),
        .rf_data         (rf_data),
        .retire_valid    (retire_valid),
        .retire_id       (retire_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      addr;
        logic [ID_W-1:0] id;
    } item_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      addr;
        logic [ID_W-1:0] id;
        logic            we;
    } exp_t;

    item_t  ubuf [N][DEPTH];
    int     uhead [N];
    int     ucnt  [N];
    exp_t   expq [$];

    logic [N-1:0] m_acc;     // model's view of 'accepted' this cycle
    int           m_ptr;     // rotating start point (stays 0 for fixed priority)
    int           n_checks;
    int           n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int u);
        return ((v >> u) & N'(1)) != '0;
    endfunction

    // Pick the first eligible unit scanning upward from ptr with wrap.
    function automatic logic [N-1:0] arbitrate(input logic [N-1:0] elig, input int ptr);
        logic [N-1:0] r;
        int           u;
        r = '0;
        for (int k = 0; k < N; k++) begin
            u = (ptr + k) % N;
            if (r == '0 && bit_of(elig, u))
                r = N'(1) << u;
        end
        return r;
    endfunction

    // Advance the model by one clock edge, using the inputs that were
    // driven during the cycle that just ended.
    task automatic step_model();
        logic [N-1:0] elig;
        logic [N-1:0] g;
        item_t        it;
        exp_t         e;
        if (rst) begin
            expq.delete();
            m_acc = '0;
            m_ptr = 0;
        end else begin
            elig = done_next_cycle & ~m_acc & {N{~wb_stall}};
            g    = arbitrate(elig, m_ptr);
            for (int u = 0; u < N; u++) begin
                if (bit_of(m_acc, u)) begin
                    uhead[u] = (uhead[u] + 1) % DEPTH;
                    ucnt[u]  = ucnt[u] - 1;
                end
            end
            for (int u = 0; u < N; u++) begin
                if (bit_of(g, u)) begin
                    it     = ubuf[u][uhead[u]];
                    e.data = it.data;
                    e.addr = it.addr;
                    e.id   = it.id;
                    e.we   = (it.addr != 5'd0);
                    expq.push_back(e);
`ifdef WB_ROUND_ROBIN_EN
                    m_ptr = (u + 1) % N;
`endif
                end
            end
            m_acc = g;
        end
    endtask

    task automatic drive(input bit add_items, input bit allow_rst, input bit force_rst);
        item_t it;
        rst      = force_rst || (allow_rst && ($urandom_range(0, 299) == 0));
        wb_stall = ($urandom_range(0, 4) == 0);
        done_next_cycle = '0;
        unit_rd         = '0;
        unit_rd_addr    = '0;
        unit_id         = '0;
        for (int u = 0; u < N; u++) begin
            if (add_items && ucnt[u] < DEPTH && $urandom_range(0, 3) == 0) begin
                it.data = $urandom;
                it.addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                it.id   = ID_W'($urandom_range(0, 7));
                ubuf[u][(uhead[u] + ucnt[u]) % DEPTH] = it;
                ucnt[u] = ucnt[u] + 1;
            end
            if (ucnt[u] > 0) begin
                it = ubuf[u][uhead[u]];
                done_next_cycle = done_next_cycle | (N'(1) << u);
                unit_rd      = unit_rd      | ((N*XLEN)'(it.data) << (u*XLEN));
                unit_rd_addr = unit_rd_addr | ((N*5)'(it.addr)    << (u*5));
                unit_id      = unit_id      | ((N*ID_W)'(it.id)   << (u*ID_W));
            end
        end
    endtask

    // Stimulus and model
    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_acc    = '0;
        m_ptr    = 0;
        for (int u = 0; u < N; u++) begin
            uhead[u] = 0;
            ucnt[u]  = 0;
        end
        rst             = 1'b1;
        wb_stall        = 1'b0;
        done_next_cycle = '0;
        unit_rd         = '0;
        unit_rd_addr    = '0;
        unit_id         = '0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            step_model();
            drive(cyc >= 4 && cyc < 3400, cyc >= 4 && cyc < 3400, cyc < 4);
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor
    initial begin
        exp_t e;
        bit   prev_rst;
        prev_rst = 1'b0;
        repeat (2) @(posedge clk);
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                check("reset_accepted",     64'(accepted),     64'd0);
                check("reset_rf_we",        64'(rf_we),        64'd0);
                check("reset_retire_valid", 64'(retire_valid), 64'd0);
                check("reset_rf_addr",      64'(rf_addr),      64'd0);
                check("reset_rf_data",      64'(rf_data),      64'd0);
                check("reset_retire_id",    64'(retire_id),    64'd0);
            end
            check("accepted", 64'(accepted), 64'(m_acc));
            if (retire_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    check("spurious_retire", 64'(retire_valid), 64'd0);
                end else begin
                    e = expq.pop_front();
                    check("retire_id", 64'(retire_id), 64'(e.id));
                    check("rf_data",   64'(rf_data),   64'(e.data));
                    check("rf_addr",   64'(rf_addr),   64'(e.addr));
                    check("rf_we",     64'(rf_we),     64'(e.we));
                end
            end else begin
                check("retire_valid_known", 64'(retire_valid), 64'd0);
                check("rf_we_idle",         64'(rf_we),        64'd0);
            end
            prev_rst = rst;
        end
    end

endmodule
`default_nettype wire
